// File: rtl/fdct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdct_pkg
// Description : Shared defaults and types for the FDCT arithmetic helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fdct_pkg;

  // Default operand width and requester count for the shared adder.
  localparam int ADD_WIDTH = 8;
  localparam int ADD_NREQ  = 4;

  // Requester index at the default requester count.
  typedef logic [$clog2(ADD_NREQ)-1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : Unsigned WIDTH-bit adder with a carry-out bit; the result is
//               WIDTH+1 bits wide so it can never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  // Zero-extend both operands so the carry lands in bit WIDTH.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter sharing one adder among NREQ requesters,
//               with a single registered response stage (valid/ready on both
//               sides, one result per cycle at full throughput).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
  import fdct_pkg::*;
#(
  parameter  int WIDTH = ADD_WIDTH,
  parameter  int NREQ  = ADD_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id
);

  // One extra bit so rr_ptr + offset never wraps before the modulo fix-up.
  localparam int IW1 = IDW + 1;
  localparam logic [IW1-1:0] c_nreq = IW1'(NREQ);
  localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);

  logic [IDW-1:0]   r_rr_ptr;
  logic             r_rsp_valid;
  logic [WIDTH:0]   r_rsp_sum;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_slot_free;
  logic [NREQ-1:0]  w_grant;
  logic             w_found;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_ptr_next;
  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH:0]   w_sum;

  // The output register can take a new result when empty or being drained.
  assign w_slot_free = ~r_rsp_valid | rsp_ready;

  // Round-robin search: first valid requester starting at rr_ptr, modulo NREQ.
  always_comb begin
    logic [IW1-1:0] pos;
    pos     = '0;
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, r_rr_ptr} + IW1'(k);
      if (pos >= c_nreq) begin
        pos = pos - c_nreq;
      end
      if (!w_found && req_valid[pos[IDW-1:0]]) begin
        w_found                = 1'b1;
        w_grant[pos[IDW-1:0]]  = 1'b1;
        w_gidx                 = pos[IDW-1:0];
      end
    end
  end

  // Ready only to the granted requester, only with a free slot, never in reset.
  assign req_ready = w_grant & {NREQ{w_slot_free & ~reset}};
  assign w_accept  = w_found & w_slot_free & ~reset;

  // Pointer moves to the requester just after the winner, wrapping to 0.
  assign w_ptr_next = (w_gidx == c_last) ? '0 : w_gidx + IDW'(1);

  // One-hot AND-OR operand mux feeding the shared adder.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_op_a = w_op_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      w_op_b = w_op_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (w_op_a),
    .b   (w_op_b),
    .sum (w_sum)
  );

  // Response register: load on accept, clear valid on drain, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum;
      r_rsp_id    <= w_gidx;
      r_rr_ptr    <= w_ptr_next;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed self-checking bench for adder_arbiter (WIDTH=8,
//               NREQ=4) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH:0]        rsp_sum;
  logic [IDW-1:0]        rsp_id;

  int n_tests;
  int n_fail;

  adder_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    logic [31:0] va;
    logic [31:0] vb;
    va = a;
    vb = b;
    req_a[i*WIDTH +: WIDTH] = va[WIDTH-1:0];
    req_b[i*WIDTH +: WIDTH] = vb[WIDTH-1:0];
  endtask

  // Check the registered response fields together.
  task automatic check_rsp(input string tag, input int v, input int s, input int id);
    check({tag, ".valid"}, 32'(rsp_valid), v);
    check({tag, ".sum"},   32'(rsp_sum),   s);
    check({tag, ".id"},    32'(rsp_id),    id);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state; requests must not see ready while reset is held.
    tick();
    req_valid = 4'b1111;
    #1;
    check("rst.ready", 32'(req_ready), 0);
    check_rsp("rst", 0, 0, 0);
    tick();
    req_valid = '0;
    reset     = 1'b0;
    tick();

    // Single request from requester 2: 100 + 55.
    set_op(2, 100, 55);
    req_valid = 4'b0100;
    #1;
    check("t1.ready", 32'(req_ready), 32'b0100);
    tick();
    check_rsp("t1", 1, 155, 2);

    // rr_ptr is now 3: with 2 and 3 valid, 3 wins.
    set_op(3, 7, 8);
    req_valid = 4'b1100;
    #1;
    check("ptr3.ready", 32'(req_ready), 32'b1000);
    tick();
    check_rsp("ptr3", 1, 15, 3);

    // All four valid continuously: grants 0,1,2,3,0 with no bubbles.
    for (int i = 0; i < NREQ; i++) set_op(i, i, 10);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr.ready", 32'(req_ready), 32'(1 << (k % NREQ)));
      tick();
      check_rsp("rr", 1, 10 + (k % NREQ), k % NREQ);
    end

    // rr_ptr is 1: accept requester 1 (20 + 30), then backpressure.
    set_op(1, 20, 30);
    req_valid = 4'b0010;
    #1;
    check("bp.acc.ready", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("bp.acc", 1, 50, 1);

    rsp_ready = 1'b0;
    set_op(0, 1, 2);
    set_op(1, 3, 4);
    req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp.ready", 32'(req_ready), 0);
      tick();
      check_rsp("bp.hold", 1, 50, 1);
    end

    // Release: search from rr_ptr=2 wraps to 0, then 1.
    rsp_ready = 1'b1;
    #1;
    check("bp.rel0.ready", 32'(req_ready), 32'b0001);
    tick();
    check_rsp("bp.rel0", 1, 3, 0);
    #1;
    check("bp.rel1.ready", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("bp.rel1", 1, 7, 1);

    // Drain with no new request: valid drops, data holds.
    req_valid = '0;
    tick();
    check_rsp("drain", 0, 7, 1);

    // Overflow: 255 + 255 = 510 with the carry bit set (rr_ptr is 2).
    set_op(2, 255, 255);
    req_valid = 4'b0100;
    #1;
    check("ovf.ready", 32'(req_ready), 32'b0100);
    tick();
    check_rsp("ovf", 1, 510, 2);
    check("ovf.bit8", 32'(rsp_sum[8]), 1);

    // Hold a result under backpressure, then reset mid-cycle.
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    check_rsp("pre_rst", 1, 510, 2);
    reset = 1'b1;
    #1;
    check_rsp("async_rst", 0, 0, 0);
    tick();
    reset     = 1'b0;
    rsp_ready = 1'b1;

    // After reset rr_ptr is 0: with 3 and 0 valid, 0 goes first, then 3.
    set_op(0, 4, 5);
    set_op(3, 9, 9);
    req_valid = 4'b1001;
    #1;
    check("post_rst0.ready", 32'(req_ready), 32'b0001);
    tick();
    check_rsp("post_rst0", 1, 9, 0);
    #1;
    check("post_rst3.ready", 32'(req_ready), 32'b1000);
    tick();
    check_rsp("post_rst3", 1, 18, 3);

    // Idle cycles leave rr_ptr at 0: with 1 and 2 valid, 1 wins.
    req_valid = '0;
    tick();
    tick();
    check("idle.valid", 32'(rsp_valid), 0);
    set_op(1, 40, 60);
    set_op(2, 1, 1);
    req_valid = 4'b0110;
    #1;
    check("idle.ready", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("idle", 1, 100, 1);
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
